// File: rtl/uart_pkg.sv
// Types and constants shared by the UART receive and transmit blocks.
package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        PARITY    = 3'd4,
        STOP      = 3'd5
    } uart_rx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through FIFO. A push into a full FIFO succeeds only when a pop
// is accepted in the same cycle. A pop from an empty FIFO is ignored.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] q,
    output logic             empty,
    output logic             full
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty   = (count_q == '0);
    // The count never exceeds DEPTH, so its top bit alone marks full.
    assign full    = count_q[AW];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign q       = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a FWFT byte FIFO.
// With UART_RX_PARITY_EN defined, frames are 8E1 and the parity_err port is added.
//
// state     | meaning
// WAIT_IDLE | wait for the line to be seen high before accepting a start bit
// IDLE      | line idle, waiting for a falling edge
// START     | timing to mid start bit, then confirm it is still low
// DATA      | sampling 8 data bits, LSB first
// PARITY    | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP      | sampling the stop bit, pushing the byte if the frame is good
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_AW      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       rdreq,
    output logic       empty,
    output logic [7:0] q,
    output logic       overrun,
    output logic       frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int               CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]    HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]    FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

    logic                      rx_meta_q, rx_sync_q;
    logic [1:0]                sync_vld_q, sync_vld_d;
    uart_rx_state_t            state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      overrun_q, overrun_d;
    logic                      frame_err_q, frame_err_d;
    logic                      par_bad;
    logic                      tick;
    logic                      push;
    logic                      fifo_full;

`ifdef UART_RX_PARITY_EN
    logic par_bad_q, par_bad_d;
    logic parity_err_q, parity_err_d;
    assign par_bad    = par_bad_q;
    assign parity_err = parity_err_q;
`else
    assign par_bad = 1'b0;
`endif

    assign tick      = (cnt_q == '0);
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    // The synchronizer's reset value is not a real line observation; WAIT_IDLE
    // trusts rx_sync_q only once two genuine samples have flowed through.
    assign sync_vld_d = {sync_vld_q[0], 1'b1};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        push        = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = parity_err_q;
`endif
        case (state_q)
            WAIT_IDLE: begin
                if (sync_vld_q[1] && rx_sync_q) state_d = IDLE;
            end
            IDLE: begin
                if (!rx_sync_q) begin
                    state_d = START;
                    cnt_d   = HALF_LOAD;
                end
            end
            START: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx_sync_q) begin
                    state_d = IDLE;
                end else begin
                    state_d   = DATA;
                    cnt_d     = FULL_LOAD;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d   = {rx_sync_q, shift_q[UART_DATA_BITS-1:1]};
                    cnt_d     = FULL_LOAD;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    par_bad_d = ^{shift_q, rx_sync_q};
                    if (^{shift_q, rx_sync_q}) parity_err_d = 1'b1;
                    cnt_d   = FULL_LOAD;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!rx_sync_q) begin
                    frame_err_d = 1'b1;
                    state_d     = WAIT_IDLE;
                end else begin
                    state_d = IDLE;
                    if (!par_bad) begin
                        push = 1'b1;
                        if (fifo_full && !rdreq) overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            sync_vld_q  <= '0;
            state_q     <= WAIT_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= rxd;
            rx_sync_q   <= rx_meta_q;
            sync_vld_q  <= sync_vld_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    uart_sync_fifo #(
        .WIDTH(UART_DATA_BITS),
        .AW   (FIFO_AW)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .din  (shift_q),
        .pop  (rdreq),
        .q    (q),
        .empty(empty),
        .full (fifo_full)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo with CLKS_PER_BIT=8, FIFO_AW=4.
module tb_uart_rx_fifo;

    localparam int C = 8;
`ifdef UART_RX_PARITY_EN
    localparam bit USE_PAR = 1'b1;
`else
    localparam bit USE_PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd;
    logic       rdreq;
    logic       empty;
    logic [7:0] q;
    logic       overrun;
    logic       frame_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLKS_PER_BIT(C),
        .FIFO_AW     (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .rdreq     (rdreq),
        .empty     (empty),
        .q         (q),
        .overrun   (overrun),
        .frame_err (frame_err)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!reset && rdreq && !empty) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected actual=%02h required=none", q);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (q !== e) begin
                    errors++;
                    $display("FAIL pop_data actual=%02h required=%02h", q, e);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        cyc(C);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (USE_PAR) send_bit(par_b);
        send_bit(stop_b);
        rxd = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] d);
        exp_q.push_back(d);
        send_frame(d, 1'b1, ^d);
    endtask

    task automatic pop_one();
        rdreq = 1'b1;
        cyc(1);
        rdreq = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        rxd   = 1'b1;
        rdreq = 1'b0;
        cyc(3);
        check("rst_empty", empty, 1);
        check("rst_q", q, 8'h00);
        check("rst_overrun", overrun, 0);
        check("rst_frame_err", frame_err, 0);
`ifdef UART_RX_PARITY_EN
        check("rst_parity_err", parity_err, 0);
`endif
        reset = 1'b0;
        cyc(5);

        // Single byte with latency measurement from the pin edge.
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1, ^8'hA5);
            begin
                int lat;
                bit seen;
                lat  = 0;
                seen = 1'b0;
                for (int k = 1; k <= 200 && !seen; k++) begin
                    @(posedge clk);
                    @(negedge clk);
                    if (!empty) begin
                        lat  = k;
                        seen = 1'b1;
                    end
                end
                check("byte_latency", lat, USE_PAR ? 87 : 79);
            end
        join
        check("head_a5", q, 8'hA5);
        pop_one();
        check("empty_after_pop", empty, 1);
        check("q_zero_when_empty", q, 8'h00);
        pop_one();
        check("pop_on_empty_ignored", empty, 1);

        // Glitch shorter than half a bit.
        rxd = 1'b0;
        cyc(2);
        rxd = 1'b1;
        cyc(30);
        check("glitch_no_byte", empty, 1);
        check("glitch_no_frame_err", frame_err, 0);
        send_good(8'h5A);
        check("after_glitch_head", q, 8'h5A);
        pop_one();

        // Overrun: 17 back-to-back bytes, the last one is dropped.
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, ^(8'(i)));
            if (i == 15) check("no_overrun_at_16", overrun, 0);
        end
        check("overrun_set", overrun, 1);
        check("full_head", q, 8'h00);
        for (int i = 0; i < 16; i++) pop_one();
        check("overrun_drained", empty, 1);
        check("overrun_sticky", overrun, 1);

        // Framing error, then recovery.
        send_frame(8'h3C, 1'b0, ^8'h3C);
        check("frame_err_set", frame_err, 1);
        check("frame_err_no_byte", empty, 1);
        cyc(20);
        send_good(8'h55);
        check("recover_head", q, 8'h55);
        check("frame_err_sticky", frame_err, 1);
        pop_one();

        // Reset during bit 3 of 0xF0 (all bits so far are low), line held low after release.
        rxd = 1'b0;
        cyc(4 * C + C / 2);
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        check("reset_clears_frame_err", frame_err, 0);
        check("reset_clears_overrun", overrun, 0);
        cyc(20);
        rxd = 1'b1;
        cyc(20 * C);
        check("reset_mid_frame_no_byte", empty, 1);
        send_good(8'h81);
        check("after_reset_head", q, 8'h81);
        pop_one();

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        check("parity_err_set", parity_err, 1);
        check("parity_bad_dropped", empty, 1);
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        check("parity_good_head", q, 8'h07);
        pop_one();
`endif

        cyc(4);
        check("scoreboard_drained", exp_q.size(), 0);
        check("final_empty", empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
